// File: rtl/neureka_package.sv
// Shared types and defaults for the masked PE serializer: control/flag structs and FSM states.
// Struct field widths follow the default PE array geometry and memory bandwidth.
package neureka_package;

  localparam int unsigned NEUREKA_PE_H_DEFAULT  = 3;
  localparam int unsigned NEUREKA_PE_W_DEFAULT  = 3;
  localparam int unsigned NEUREKA_NR_PE         = NEUREKA_PE_H_DEFAULT * NEUREKA_PE_W_DEFAULT;
  localparam int unsigned NEUREKA_MEM_BANDWIDTH = 32;
  localparam int unsigned NEUREKA_BEAT_W        = 8;
  localparam int unsigned NEUREKA_PE_IDX_W      = (NEUREKA_NR_PE > 1) ? $clog2(NEUREKA_NR_PE) : 1;

  typedef struct packed {
    logic                        start;
    logic [NEUREKA_NR_PE-1:0]    pe_mask;
    logic [NEUREKA_BEAT_W-1:0]   nb_beats;
  } ctrl_pe_serializer_t;

  typedef struct packed {
    logic                        busy;
    logic [NEUREKA_PE_IDX_W-1:0] cur_pe;
    logic                        done;
  } flags_pe_serializer_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pe_ser_state_e;

  // A programmed beat count of zero means one beat per PE.
  function automatic logic [NEUREKA_BEAT_W-1:0] eff_beats(input logic [NEUREKA_BEAT_W-1:0] nb);
    return (nb == '0) ? NEUREKA_BEAT_W'(1) : nb;
  endfunction

endpackage

// File: rtl/neureka_lzc_onehot.sv
// Index of the lowest set bit of a mask; combinational, no handshake.
// An all-zero mask yields index 0.
module neureka_lzc_onehot #(
  parameter  int unsigned N  = 9,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  mask,
  output logic [IW-1:0] idx
);

  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/neureka_masked_pe_serializer.sv
// Serializes enabled PE streams in ascending order, nb_beats each; zero latency mux, or +1 cycle with
// NEUREKA_SERIALIZER_OUTREG_EN (one-entry output register, full throughput); only the current PE sees ready.
module neureka_masked_pe_serializer
  import neureka_package::*;
#(
  parameter int unsigned NR_PE  = NEUREKA_NR_PE,
  parameter int unsigned DW     = NEUREKA_MEM_BANDWIDTH,
  parameter int unsigned BEAT_W = NEUREKA_BEAT_W
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  ctrl_pe_serializer_t   ctrl_i,
  output flags_pe_serializer_t  flags_o,
  input  logic [DW-1:0]         push_data_i  [NR_PE],
  input  logic [DW/8-1:0]       push_strb_i  [NR_PE],
  input  logic [NR_PE-1:0]      push_valid_i,
  output logic [NR_PE-1:0]      push_ready_o,
  output logic [DW-1:0]         pop_data_o,
  output logic [DW/8-1:0]       pop_strb_o,
  output logic                  pop_valid_o,
  input  logic                  pop_ready_i,
  output logic                  last_o
);

  localparam int unsigned IW = NEUREKA_PE_IDX_W;

  pe_ser_state_e      state;
  logic [NR_PE-1:0]   mask_q, mask_rest, lzc_in;
  logic [BEAT_W-1:0]  nb_q, beat_cnt;
  logic [IW-1:0]      cur_pe, lzc_idx;
  logic               run_act, src_vld, src_rdy, in_hs, pe_last, job_last, out_last_hs;
  logic [DW-1:0]      src_data;
  logic [DW/8-1:0]    src_strb;

  assign mask_rest = mask_q & ~(NR_PE'(1) << cur_pe);
  // One finder serves both the start scan and the advance to the next enabled PE.
  assign lzc_in    = (state == IDLE) ? ctrl_i.pe_mask : mask_rest;

  neureka_lzc_onehot #(.N(NR_PE)) i_lzc (
    .mask (lzc_in),
    .idx  (lzc_idx)
  );

  // mask_q empties once every beat is accepted, which also idles the input side while a
  // registered output drains.
  assign run_act  = (state == RUN) && !clear_i && (mask_q != '0);
  assign src_vld  = run_act && push_valid_i[cur_pe];
  assign src_data = push_data_i[cur_pe];
  assign src_strb = push_strb_i[cur_pe];
  assign in_hs    = src_vld && src_rdy;
  assign pe_last  = (beat_cnt == nb_q - BEAT_W'(1));
  assign job_last = pe_last && (mask_rest == '0);

  always_comb begin
    push_ready_o         = '0;
    push_ready_o[cur_pe] = run_act && src_rdy;
  end

`ifdef NEUREKA_SERIALIZER_OUTREG_EN
  logic            reg_full, reg_last;
  logic [DW-1:0]   reg_data;
  logic [DW/8-1:0] reg_strb;

  assign src_rdy     = !reg_full || pop_ready_i;
  assign pop_valid_o = reg_full && !clear_i;
  assign pop_data_o  = reg_data;
  assign pop_strb_o  = reg_strb;
  assign last_o      = reg_full && reg_last;
  assign out_last_hs = pop_valid_o && pop_ready_i && reg_last;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reg_full <= 1'b0;
      reg_last <= 1'b0;
      reg_data <= '0;
      reg_strb <= '0;
    end else if (clear_i) begin
      reg_full <= 1'b0;
      reg_last <= 1'b0;
    end else if (in_hs) begin
      reg_full <= 1'b1;
      reg_last <= job_last;
      reg_data <= src_data;
      reg_strb <= src_strb;
    end else if (pop_ready_i) begin
      reg_full <= 1'b0;
    end
  end
`else
  assign src_rdy     = pop_ready_i;
  assign pop_valid_o = src_vld;
  assign pop_data_o  = src_data;
  assign pop_strb_o  = src_strb;
  assign last_o      = src_vld && job_last;
  assign out_last_hs = in_hs && job_last;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      mask_q   <= '0;
      nb_q     <= BEAT_W'(1);
      beat_cnt <= '0;
      cur_pe   <= '0;
    end else if (clear_i) begin
      state    <= IDLE;
      mask_q   <= '0;
      beat_cnt <= '0;
      cur_pe   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ctrl_i.start) begin
            if (ctrl_i.pe_mask != '0) begin
              state    <= RUN;
              mask_q   <= ctrl_i.pe_mask;
              nb_q     <= eff_beats(ctrl_i.nb_beats);
              cur_pe   <= lzc_idx;
              beat_cnt <= '0;
            end else begin
              state <= DONE;
            end
          end
        end
        RUN: begin
          if (in_hs) begin
            if (pe_last) begin
              beat_cnt <= '0;
              mask_q   <= mask_rest;
              cur_pe   <= lzc_idx;
            end else begin
              beat_cnt <= beat_cnt + BEAT_W'(1);
            end
          end
          if (out_last_hs) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign flags_o.busy   = (state == RUN);
  assign flags_o.done   = (state == DONE);
  assign flags_o.cur_pe = cur_pe;

endmodule

// File: tb/tb_neureka_masked_pe_serializer.sv
// Randomized bench for neureka_masked_pe_serializer: per-PE source queues, expected-beat scoreboard,
// negedge monitor; timing expectations adapt to NEUREKA_SERIALIZER_OUTREG_EN.
module tb_neureka_masked_pe_serializer;
  import neureka_package::*;

  localparam int NR_PE = 9;
  localparam int DW    = 32;
  localparam int SW    = DW / 8;
`ifdef NEUREKA_SERIALIZER_OUTREG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  typedef struct packed {
    logic          last;
    logic [3:0]    pe;
    logic [SW-1:0] strb;
    logic [DW-1:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n, clear;
  ctrl_pe_serializer_t  ctrl;
  flags_pe_serializer_t flags;
  logic [DW-1:0]    push_data [NR_PE];
  logic [SW-1:0]    push_strb [NR_PE];
  logic [NR_PE-1:0] push_valid, push_ready, hs_q, job_mask;
  logic [DW-1:0]    pop_data;
  logic [SW-1:0]    pop_strb;
  logic             pop_valid, pop_ready, last;

  logic [DW+SW-1:0] pe_q [NR_PE][$];
  beat_t            exp_q[$];
  int  checks = 0, errors = 0, hs_total = 0;
  bit  bp_en = 0, gap_en = 0, viol = 0;

  always #5 clk = ~clk;

  neureka_masked_pe_serializer #(.NR_PE(NR_PE), .DW(DW), .BEAT_W(8)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .clear_i      (clear),
    .ctrl_i       (ctrl),
    .flags_o      (flags),
    .push_data_i  (push_data),
    .push_strb_i  (push_strb),
    .push_valid_i (push_valid),
    .push_ready_o (push_ready),
    .pop_data_o   (pop_data),
    .pop_strb_o   (pop_strb),
    .pop_valid_o  (pop_valid),
    .pop_ready_i  (pop_ready),
    .last_o       (last)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // PE sources: valid stays up with stable data until accepted; optional random gaps.
  initial forever begin
    @(posedge clk);
    #1;
    for (int p = 0; p < NR_PE; p++) begin
      if (hs_q[p] && pe_q[p].size() > 0) pe_q[p].delete(0);
      if (!(push_valid[p] && !hs_q[p])) begin
        if (pe_q[p].size() > 0 && (!gap_en || $urandom_range(1, 0) == 1)) begin
          push_valid[p] = 1'b1;
          {push_strb[p], push_data[p]} = pe_q[p][0];
        end else begin
          push_valid[p] = 1'b0;
        end
      end
    end
    pop_ready = bp_en ? ($urandom_range(1, 0) == 1) : 1'b1;
  end

  // Monitor: scoreboard compare on every output handshake, plus stall stability.
  logic        prev_stall = 1'b0;
  logic [63:0] prev_out   = '0;
  beat_t       mon_e;
  initial forever begin
    @(negedge clk);
    hs_q = push_valid & push_ready;
    if (rst_n && !clear) begin
      if (prev_stall) chk("stall_stable", 64'({pop_valid, last, pop_strb, pop_data}), prev_out);
      if (pop_valid && pop_ready) begin
        hs_total++;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'(1), 64'(0));
        end else begin
          mon_e = exp_q.pop_front();
          chk("beat", 64'({last, pop_strb, pop_data}), 64'({mon_e.last, mon_e.strb, mon_e.data}));
`ifndef NEUREKA_SERIALIZER_OUTREG_EN
          chk("cur_pe", 64'(flags.cur_pe), 64'(mon_e.pe));
`endif
        end
      end
      if ((push_ready & ~job_mask) != '0) viol = 1'b1;
    end
    prev_stall = rst_n && !clear && pop_valid && !pop_ready;
    prev_out   = 64'({pop_valid, last, pop_strb, pop_data});
  end

  // Reference model: enabled PEs in ascending order, nb beats each (0 means 1), last on the final one.
  task automatic load_job(input logic [8:0] mask, input logic [7:0] nb, output int total);
    int nbe, hi;
    beat_t e;
    nbe = (nb == 0) ? 1 : int'(nb);
    hi = -1;
    total = 0;
    for (int p = 0; p < NR_PE; p++) if (mask[p]) hi = p;
    for (int p = 0; p < NR_PE; p++) begin
      if (mask[p]) begin
        for (int b = 0; b < nbe; b++) begin
          e.data = $urandom;
          e.strb = SW'($urandom_range(15, 0));
          e.pe   = 4'(p);
          e.last = (p == hi) && (b == nbe - 1);
          pe_q[p].push_back({e.strb, e.data});
          exp_q.push_back(e);
          total++;
        end
      end
    end
    job_mask = mask;
  endtask

  task automatic do_start(input logic [8:0] mask, input logic [7:0] nb);
    @(posedge clk);
    #1;
    ctrl.start = 1'b1;
    ctrl.pe_mask = mask;
    ctrl.nb_beats = nb;
    @(posedge clk);
    #1;
    ctrl.start = 1'b0;
    ctrl.pe_mask = 9'($urandom);
    ctrl.nb_beats = 8'($urandom);
  endtask

  task automatic flush();
    for (int p = 0; p < NR_PE; p++) pe_q[p].delete();
    exp_q.delete();
    push_valid = '0;
    hs_q = '0;
  endtask

  task automatic run_job(input logic [8:0] mask, input logic [7:0] nb, input bit timed);
    int total, n, vcnt;
    bit got, any_busy;
    load_job(mask, nb, total);
    viol = 1'b0;
    do_start(mask, nb);
    n = 0; vcnt = 0; got = 0; any_busy = 0;
    while (!got && n < 4000) begin
      @(negedge clk);
      n++;
      if (pop_valid) vcnt++;
      if (flags.busy) any_busy = 1;
      if (flags.done) begin
        got = 1;
        chk("busy_at_done", 64'(flags.busy), 64'(0));
      end
    end
    chk("done_seen", 64'(got), 64'(1));
    chk("all_beats_out", 64'(exp_q.size()), 64'(0));
    chk("masked_pe_ready", 64'(viol), 64'(0));
    chk("busy_seen", 64'(any_busy), 64'(mask != 0));
    if (timed) begin
      chk("done_cycle", 64'(n), 64'((total == 0) ? 1 : total + 1 + LAT));
      chk("valid_cycles", 64'(vcnt), 64'(total));
    end
    @(negedge clk);
    chk("done_one_cycle", 64'(flags.done), 64'(0));
  endtask

  initial begin
    int total, base, k;
    bit done_seen;
    rst_n = 1'b0; clear = 1'b0; ctrl = '0; pop_ready = 1'b0;
    push_valid = '0; hs_q = '0; job_mask = '0;
    for (int p = 0; p < NR_PE; p++) begin
      push_data[p] = '0;
      push_strb[p] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", 64'({pop_valid, last, flags.busy, flags.done, flags.cur_pe}), 64'(0));
    chk("rst_push_ready", 64'(push_ready), 64'(0));
    rst_n = 1'b1;

    run_job(9'h1FF, 8'd2, 1);
    run_job(9'h105, 8'd1, 1);
    run_job(9'h000, 8'd5, 1);
    run_job(9'h022, 8'd0, 1);

    // Clear after five delivered beats, then a full job must run cleanly.
    load_job(9'h1FF, 8'd2, total);
    base = hs_total;
    do_start(9'h1FF, 8'd2);
    k = 0;
    while (hs_total < base + 5 && k < 200) begin
      @(negedge clk);
      #1;
      k++;
    end
    @(posedge clk);
    #1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    @(negedge clk);
    chk("clear_idle", 64'({flags.busy, pop_valid, push_ready}), 64'(0));
    done_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (flags.done) done_seen = 1;
    end
    chk("clear_no_done", 64'(done_seen), 64'(0));
    chk("clear_beats", 64'(hs_total - base), 64'(5));
    flush();
    run_job(9'h1FF, 8'd2, 1);

    // Asynchronous reset mid-job.
    load_job(9'h0F3, 8'd3, total);
    do_start(9'h0F3, 8'd3);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", 64'({pop_valid, last, flags.busy, flags.done, push_ready}), 64'(0));
    flush();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_no_done", 64'(flags.done), 64'(0));

    bp_en = 1; gap_en = 1;
    repeat (14) run_job(9'($urandom), 8'($urandom_range(4, 0)), 0);
    bp_en = 0; gap_en = 0;
    run_job(9'h1FF, 8'd2, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
